// File: rtl/lht_access_scheduler_if.sv
// Requester-side channels of the LHT access scheduler: the fetch-stage
// history lookup and the resolved-branch update offer.
interface lht_access_scheduler_if;
  logic       lookup_req;
  logic [4:0] lookup_idx;
  logic       lookup_gnt;
  logic [4:0] lookup_hist;
  logic       lookup_stale;
  logic       upd_valid;
  logic [4:0] upd_idx;
  logic       upd_taken;
  logic       upd_ready;

  // Requesters: fetch drives lookups, branch resolution drives updates.
  modport master (
    output lookup_req, lookup_idx, upd_valid, upd_idx, upd_taken,
    input  lookup_gnt, lookup_hist, lookup_stale, upd_ready
  );

  // Scheduler side.
  modport slave (
    input  lookup_req, lookup_idx, upd_valid, upd_idx, upd_taken,
    output lookup_gnt, lookup_hist, lookup_stale, upd_ready
  );
endinterface

// File: rtl/lht_access_scheduler.sv
// Arbitrates the single address/update port of the 32-entry local history
// table. Lookups win the port; updates wait in a small FIFO and drain when
// the port is idle, or are forced through after STARVE_LIMIT lost cycles.
// Lookups whose index matches a queued update are flagged stale.
module lht_access_scheduler #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  lht_access_scheduler_if.slave    bus,
  output logic                     lht_update_shft_reg,
  output logic                     lht_shft_value,
  output logic [4:0]               lht_addr,
  input  logic [4:0]               lht_entry,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  // Queue storage; valid bits track which slots hold a pending update.
  logic [4:0]       idx_mem_r   [DEPTH];
  logic             taken_mem_r [DEPTH];
  logic [DEPTH-1:0] valid_r;

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [3:0]    starve_cnt_r;

  logic       nonempty_s;
  logic       upd_ready_s;
  logic       push_s;
  logic       upd_sel_s;
  logic       stale_hit_s;
  logic [4:0] head_idx_s;
  logic       head_taken_s;

  // Port arbitration: an update takes the port when nothing is looking up or
  // when it has lost enough times in a row. Held off while reset is applied
  // so discarded entries never reach the table.
  always_comb begin
    nonempty_s   = (count_r != {CW{1'b0}});
    upd_ready_s  = (count_r < COUNT_FULL);
    push_s       = rst_n & bus.upd_valid & upd_ready_s;
    head_idx_s   = idx_mem_r[rd_ptr_r];
    head_taken_s = taken_mem_r[rd_ptr_r];
    upd_sel_s    = rst_n & nonempty_s &
                   (~bus.lookup_req | (starve_cnt_r == STARVE_MAX));
  end

  // Stale detection: any pending (already valid) update to the looked-up index.
  always_comb begin
    stale_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      stale_hit_s = stale_hit_s | (valid_r[i] & (idx_mem_r[i] == bus.lookup_idx));
    end
  end

  // Drive the table port and the requester responses.
  always_comb begin
    lht_update_shft_reg = 1'b0;
    lht_shft_value      = 1'b0;
    lht_addr            = bus.lookup_idx;
    bus.lookup_gnt      = 1'b0;
    bus.lookup_stale    = 1'b0;
    bus.lookup_hist     = lht_entry;
    bus.upd_ready       = upd_ready_s;
    fifo_count          = count_r;
    if (upd_sel_s) begin
      lht_update_shft_reg = 1'b1;
      lht_shft_value      = head_taken_s;
      lht_addr            = head_idx_s;
    end else begin
      bus.lookup_gnt   = bus.lookup_req;
      bus.lookup_stale = bus.lookup_req & stale_hit_s;
    end
  end

  // Payload write on accept; payload needs no reset since valid_r guards it.
  always_ff @(posedge clk) begin
    if (push_s) begin
      idx_mem_r[wr_ptr_r]   <= bus.upd_idx;
      taken_mem_r[wr_ptr_r] <= bus.upd_taken;
    end
  end

  // Queue pointers, occupancy, valid bits and the starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      starve_cnt_r <= 4'd0;
      valid_r      <= {DEPTH{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r          <= wr_ptr_r + PTR_ONE;
        valid_r[wr_ptr_r] <= 1'b1;
      end
      if (upd_sel_s) begin
        rd_ptr_r          <= rd_ptr_r + PTR_ONE;
        valid_r[rd_ptr_r] <= 1'b0;
      end
      case ({push_s, upd_sel_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
      // Here a nonempty queue without a pop means the head lost arbitration.
      if (upd_sel_s || !nonempty_s) begin
        starve_cnt_r <= 4'd0;
      end else if (bus.lookup_req && (starve_cnt_r != STARVE_MAX)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

endmodule

// File: doc/lht_access_scheduler.md
Name: lht_access_scheduler

Overview:
- Owns the single address/update port of the 32-entry local history table (LHT) of 5-bit shift registers.
- Shares that port between two requesters:
  - fetch-stage history lookups, which have priority;
  - resolved-branch history updates, which are buffered in a small FIFO and drained when the port is free.
- A starvation counter guarantees updates drain under continuous lookup traffic.
- A hazard flag marks lookups whose history is stale because an update to the same index is still queued.

Parameters:
- DEPTH, 4: update FIFO entries (power of 2, 2..16).
- STARVE_LIMIT, 3: consecutive cycles an update may lose arbitration before it is forced through (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- lookup_req  in  1  fetch requests a history read this cycle
- lookup_idx  in  5  LHT index for the lookup
- lookup_gnt  out  1  lookup owns the LHT port this cycle; lookup_hist is valid
- lookup_hist  out  5  history for lookup_idx (pass-through of lht_entry)
- lookup_stale  out  1  lookup_gnt and a queued update targets lookup_idx
- upd_valid  in  1  resolved branch update offered
- upd_idx  in  5  LHT index to update
- upd_taken  in  1  branch outcome, shifted into history MSB
- upd_ready  out  1  FIFO can accept (count < DEPTH)
- lht_update_shft_reg  out  1  LHT write strobe
- lht_shft_value  out  1  outcome bit to LHT
- lht_addr  out  5  LHT address (read and write)
- lht_entry  in  5  LHT combinational read data at lht_addr
- fifo_count  out  $clog2(DEPTH)+1  queued updates

Behaviour:
- Reset (rst_n low at posedge clk):
  - wr_ptr, rd_ptr, count and starve_cnt go to 0; all FIFO valid bits clear.
  - Queued updates are discarded, including on reset mid-operation.
  - While rst_n is low, pushes and pops are ignored.
  - After the reset edge: upd_ready=1, fifo_count=0, lht_update_shft_reg=0, lookup_gnt=lookup_req.
- Push:
  - upd_valid && upd_ready writes {upd_idx, upd_taken} at wr_ptr at the clock edge; wr_ptr wraps modulo DEPTH.
  - No bypass: an entry pushed in cycle N can pop no earlier than N+1.
  - upd_ready=0 when count==DEPTH; upd_valid while full is ignored and the producer holds.
- Arbitration (combinational, per cycle):
  - upd_sel = (count!=0) && (!lookup_req || starve_cnt==STARVE_LIMIT).
  - lookup_gnt = lookup_req && !upd_sel.
  - lht_addr = upd_sel ? head.idx : lookup_idx.
  - lht_update_shft_reg = upd_sel; lht_shft_value = head.taken (0 when !upd_sel).
  - lookup_hist = lht_entry.
  - No lookup and empty FIFO: lht_addr = lookup_idx, strobe=0.
- Pop: when upd_sel, the LHT shifts at the edge, rd_ptr advances modulo DEPTH and the entry's valid bit clears.
- Count: push only +1; pop only −1; push and pop in the same cycle leaves count unchanged (only possible when count was 1..DEPTH−1).
- Starvation counter:
  - starve_cnt +1 (saturating at STARVE_LIMIT) when count!=0 && lookup_req && !upd_sel.
  - Cleared on pop, or when count==0.
  - A forced update takes the port for one cycle, then the counter restarts from 0.
- Stale flag:
  - lookup_stale = lookup_gnt && OR over valid entries of (entry.idx == lookup_idx).
  - An entry pushed in the same cycle is not yet valid and does not set the flag.
  - Fetch treats a stale history as low-confidence; the scheduler takes no further action.
- Latency:
  - Lookup: 0 cycles (same-cycle grant and data).
  - Update: ≥1 cycle from accept to the LHT write; worst case with continuous lookups is (STARVE_LIMIT+1)×(position in queue).

Test Plan:
- Reset, then push {idx=5, taken=1} with lookup_req=0 → next cycle lht_update_shft_reg=1, lht_addr=5, lht_shft_value=1, fifo_count returns to 0.
- lookup_req=1 held continuously with idx=9 and one update queued for idx=3 → lookup_gnt=1 for 3 cycles, then the 4th cycle has lookup_gnt=0, strobe=1, lht_addr=3, then lookups resume.
- 4 pushes with lookup_req held and starve forcing disabled by pattern → upd_ready=0 after the 4th, 5th upd_valid not accepted, fifo_count=4; entries drain in order with no drops.
- Queue an update for idx=12, then lookup idx=12 → lookup_stale=1; lookup idx=13 → lookup_stale=0; after the idx=12 update pops, lookup idx=12 → lookup_stale=0.
- Simultaneous push and pop at count=2 → count stays 2, order is preserved across rd_ptr/wr_ptr wrap (push 6 entries total through a DEPTH=4 FIFO).
- Assert rst_n=0 with 3 queued entries → next cycle fifo_count=0, upd_ready=1, no LHT strobe is issued for the discarded entries.
